// File: rtl/vending_pkg.sv
// Shared vending definitions: one-hot buyer states and the cola price,
// which the vendor FSM also uses.
package vending_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    PAY  = 4'b0010,
    GAP  = 4'b0100,
    WAIT = 4'b1000
  } state_t;

  localparam int COIN_PRICE_DEF = 3;

endpackage

// File: rtl/cola_buyer_fsm_if.sv
// Buyer <-> vendor/customer signal bundle. Protocol: pi_buy is a level sampled every
// cycle; po_money, pi_cola, po_done and po_err are single-cycle pulses with no back-pressure.
interface cola_buyer_fsm_if #(
  parameter int CNT_W = 8
);
  import vending_pkg::*;

  logic             pi_buy;
  logic             pi_cola;
  logic             po_money;
  logic             po_busy;
  logic             po_done;
  logic             po_err;
  logic [CNT_W-1:0] po_cola_cnt;
  state_t           dbg_state;

  modport master (
    input  pi_buy, pi_cola,
    output po_money, po_busy, po_done, po_err, po_cola_cnt, dbg_state
  );

  modport slave (
    output pi_buy, pi_cola,
    input  po_money, po_busy, po_done, po_err, po_cola_cnt, dbg_state
  );

endinterface

// File: rtl/cycle_timer.sv
// Clearable up-counter with a terminal-count compare; shared by the GAP and WAIT phases.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/cola_buyer_fsm.sv
// Customer-side buyer: pays COIN_PRICE spaced coins, waits for the cola, reports done/err.
// Build option: define BUY_QUEUE_EN to hold one purchase request that arrives while busy.
module cola_buyer_fsm
  import vending_pkg::*;
#(
  parameter int COIN_PRICE = COIN_PRICE_DEF,
  parameter int GAP_CNT    = 4,
  parameter int TIMEOUT    = 8,
  parameter int CNT_W      = 8
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  cola_buyer_fsm_if.master  bus
);

  localparam int TMAX = (GAP_CNT > TIMEOUT) ? GAP_CNT : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(COIN_PRICE + 1);

  state_t           state_q, state_nxt;
  logic [CW-1:0]    coin_q, coin_nxt;
  logic             timer_clr, timer_en, timer_tc;
  logic [TW-1:0]    timer_tc_val;
  logic             done_set, err_set;
  logic             money_q, done_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pend_q;

  cycle_timer #(.W(TW)) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (timer_clr),
    .en        (timer_en),
    .tc_val    (timer_tc_val),
    .tc        (timer_tc)
  );

  always_comb begin
    state_nxt    = state_q;
    coin_nxt     = coin_q;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    timer_tc_val = '0;
    done_set     = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        coin_nxt  = '0;
        if (bus.pi_buy || pend_q) state_nxt = PAY;
      end
      PAY: begin
        timer_clr = 1'b1;
        coin_nxt  = coin_q + 1'b1;
        state_nxt = (coin_q == CW'(COIN_PRICE - 1)) ? WAIT : GAP;
      end
      GAP: begin
        timer_en     = 1'b1;
        timer_tc_val = TW'(GAP_CNT - 1);
        if (timer_tc) state_nxt = PAY;
      end
      WAIT: begin
        timer_en     = 1'b1;
        timer_tc_val = TW'(TIMEOUT - 1);
        // A cola arriving on the timeout cycle still counts as a successful buy.
        if (bus.pi_cola) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end else if (timer_tc) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      coin_q  <= '0;
      money_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      coin_q  <= coin_nxt;
      money_q <= (state_nxt == PAY);
      done_q  <= done_set;
      err_q   <= err_set;
      if (done_set && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef BUY_QUEUE_EN
  // Leaving IDLE consumes the pending request, so it is cleared whenever IDLE is seen.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_q <= 1'b0;
    end else if (state_q == IDLE) begin
      pend_q <= 1'b0;
    end else if (bus.pi_buy) begin
      pend_q <= 1'b1;
    end
  end
`else
  assign pend_q = 1'b0;
`endif

  assign bus.po_money    = money_q;
  assign bus.po_busy     = (state_q != IDLE);
  assign bus.po_done     = done_q;
  assign bus.po_err      = err_q;
  assign bus.po_cola_cnt = cnt_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_cola_buyer_fsm.sv
// Directed bench for cola_buyer_fsm with a small behavioural vendor in the loop.
module tb_cola_buyer_fsm;
  import vending_pkg::*;

  localparam int CNT_W = 2;
  localparam int NLOG  = 128;

  // clock / reset
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  cola_buyer_fsm_if #(.CNT_W(CNT_W)) bus ();

  cola_buyer_fsm #(
    .COIN_PRICE (3),
    .GAP_CNT    (4),
    .TIMEOUT    (8),
    .CNT_W      (CNT_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // vendor: one registered cola pulse after the third coin
  logic       vendor_en  = 1'b1;
  logic       force_cola = 1'b0;
  logic       vend_cola;
  logic [1:0] vend_coins;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vend_coins <= '0;
      vend_cola  <= 1'b0;
    end else begin
      vend_cola <= 1'b0;
      if (bus.po_money) begin
        if (vend_coins == 2'd2) begin
          vend_coins <= '0;
          vend_cola  <= 1'b1;
        end else begin
          vend_coins <= vend_coins + 2'd1;
        end
      end
    end
  end

  assign bus.pi_cola = vendor_en ? vend_cola : force_cola;

  // stimulus tables and per-cycle logs
  bit         buy_at  [NLOG];
  bit         cola_at [NLOG];
  logic       money_log [NLOG];
  logic       done_log  [NLOG];
  logic       err_log   [NLOG];
  logic       busy_log  [NLOG];
  logic [3:0] state_log [NLOG];
  logic [CNT_W-1:0] cnt_log [NLOG];
  int money_tot, done_tot, err_tot;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < NLOG; i++) begin
      buy_at[i]  = 1'b0;
      cola_at[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n  = 1'b0;
    bus.pi_buy = 1'b0;
    force_cola = 1'b0;
    clear_tables();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Cycle c is the period after the c-th rising edge; outputs are logged at its falling
  // edge, then the inputs for that cycle are applied. Ends at the falling edge of cycle n.
  task automatic run(input int n);
    money_tot = 0;
    done_tot  = 0;
    err_tot   = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge sys_clk);
      money_log[c] = bus.po_money;
      done_log[c]  = bus.po_done;
      err_log[c]   = bus.po_err;
      busy_log[c]  = bus.po_busy;
      state_log[c] = bus.dbg_state;
      cnt_log[c]   = bus.po_cola_cnt;
      money_tot += int'(bus.po_money);
      done_tot  += int'(bus.po_done);
      err_tot   += int'(bus.po_err);
      bus.pi_buy = buy_at[c];
      force_cola = cola_at[c];
    end
    @(negedge sys_clk);
    bus.pi_buy = 1'b0;
    force_cola = 1'b0;
  endtask

  initial begin
    bus.pi_buy = 1'b0;
    clear_tables();

    // reset state
    @(negedge sys_clk);
    check("rst_busy",  bus.po_busy, 0);
    check("rst_money", bus.po_money, 0);
    check("rst_done",  bus.po_done, 0);
    check("rst_err",   bus.po_err, 0);
    check("rst_cnt",   bus.po_cola_cnt, 0);
    check("rst_state", bus.dbg_state, 4'b0001);

    // 1: nominal purchase with the vendor in the loop
    do_reset();
    vendor_en = 1'b1;
    buy_at[0] = 1'b1;
    run(16);
    check("t1_busy0",   busy_log[0], 0);
    check("t1_money1",  money_log[1], 1);
    check("t1_busy1",   busy_log[1], 1);
    check("t1_money2",  money_log[2], 0);
    check("t1_money6",  money_log[6], 1);
    check("t1_money11", money_log[11], 1);
    check("t1_money_n", money_tot, 3);
    check("t1_state12", state_log[12], 4'b1000);
    check("t1_done12",  done_log[12], 0);
    check("t1_done13",  done_log[13], 1);
    check("t1_done_n",  done_tot, 1);
    check("t1_err_n",   err_tot, 0);
    check("t1_busy13",  busy_log[13], 0);
    check("t1_cnt13",   cnt_log[13], 1);

    // 3: reset in the middle of GAP, count already 1
    clear_tables();
    buy_at[0] = 1'b1;
    run(7);
    check("t3_pre_busy", bus.po_busy, 1);
    check("t3_pre_cnt",  bus.po_cola_cnt, 1);
    sys_rst_n = 1'b0;
    #1;
    check("t3_rst_busy",  bus.po_busy, 0);
    check("t3_rst_cnt",   bus.po_cola_cnt, 0);
    check("t3_rst_money", bus.po_money, 0);
    check("t3_rst_state", bus.dbg_state, 4'b0001);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_tables();
    buy_at[0] = 1'b1;
    run(16);
    check("t3_money_n", money_tot, 3);
    check("t3_done13",  done_log[13], 1);
    check("t3_err_n",   err_tot, 0);
    check("t3_cnt15",   cnt_log[15], 1);

    // 2: vendor silent -> timeout
    do_reset();
    vendor_en = 1'b0;
    buy_at[0] = 1'b1;
    run(24);
    check("t2_state12", state_log[12], 4'b1000);
    check("t2_state19", state_log[19], 4'b1000);
    check("t2_err19",   err_log[19], 0);
    check("t2_err20",   err_log[20], 1);
    check("t2_err_n",   err_tot, 1);
    check("t2_done_n",  done_tot, 0);
    check("t2_busy19",  busy_log[19], 1);
    check("t2_busy20",  busy_log[20], 0);
    check("t2_cnt23",   cnt_log[23], 0);

    // 4: extra requests while busy
    do_reset();
    vendor_en = 1'b1;
    buy_at[0] = 1'b1;
    buy_at[3] = 1'b1;
    buy_at[8] = 1'b1;
    run(32);
`ifdef BUY_QUEUE_EN
    check("t4_money_n", money_tot, 6);
    check("t4_money14", money_log[14], 1);
    check("t4_done26",  done_log[26], 1);
    check("t4_done_n",  done_tot, 2);
    check("t4_cnt31",   cnt_log[31], 2);
`else
    check("t4_money_n", money_tot, 3);
    check("t4_money14", money_log[14], 0);
    check("t4_done_n",  done_tot, 1);
    check("t4_cnt31",   cnt_log[31], 1);
`endif

    // 5: five back-to-back purchases, 2-bit saturating count
    do_reset();
    vendor_en = 1'b1;
    for (int k = 0; k < 5; k++) buy_at[13 * k] = 1'b1;
    run(70);
    check("t5_cnt14",  cnt_log[14], 1);
    check("t5_cnt27",  cnt_log[27], 2);
    check("t5_cnt40",  cnt_log[40], 3);
    check("t5_cnt53",  cnt_log[53], 3);
    check("t5_cnt66",  cnt_log[66], 3);
    check("t5_done65", done_log[65], 1);
    check("t5_done_n", done_tot, 5);
    check("t5_money_n", money_tot, 15);

    // 6: cola on the timeout cycle wins; cola during GAP is ignored
    do_reset();
    vendor_en   = 1'b0;
    buy_at[0]   = 1'b1;
    cola_at[3]  = 1'b1;
    cola_at[19] = 1'b1;
    run(24);
    check("t6_done4",  done_log[4], 0);
    check("t6_cnt5",   cnt_log[5], 0);
    check("t6_state5", state_log[5], 4'b0100);
    check("t6_done20", done_log[20], 1);
    check("t6_err20",  err_log[20], 0);
    check("t6_err_n",  err_tot, 0);
    check("t6_done_n", done_tot, 1);
    check("t6_cnt21",  cnt_log[21], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
